// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount arbiter: width/latency derivations,
// the response entry layout and the nibble popcount helper.
package popcount_pkg;

    localparam int NUM_REQ = 4;
    localparam int IN_BITS = 32;

    function automatic int id_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int out_bits(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int pipe_latency(input int w);
        return $clog2(w) - 1;
    endfunction

    localparam int DEF_ID_BITS  = id_bits(NUM_REQ);
    localparam int DEF_OUT_BITS = out_bits(IN_BITS);

    typedef struct packed {
        logic [DEF_ID_BITS-1:0]  id;
        logic [DEF_OUT_BITS-1:0] sum;
    } rsp_entry_t;

    function automatic logic [2:0] nibble_ones(input logic [3:0] n);
        return {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
    endfunction

endpackage

// File: rtl/popcount_arbiter_if.sv
// Request/response bus of the popcount arbiter; master drives requests,
// slave (the arbiter) grants and returns results.
interface popcount_arbiter_if
    import popcount_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int InBits = 32
) ();
    localparam int IdBits  = id_bits(NumReq);
    localparam int OutBits = out_bits(InBits);

    logic [NumReq-1:0]        req_valid;
    logic [NumReq*InBits-1:0] req_bits;
    logic [NumReq-1:0]        req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IdBits-1:0]        rsp_id;
    logic [OutBits-1:0]       rsp_sum;

    modport master (
        output req_valid, req_bits, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_bits, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/popcount_rsp_fifo.sv
// Synchronous response FIFO whose head entry and valid flag are registered,
// so a push into an empty FIFO is visible on the very next cycle.
module popcount_rsp_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);
    localparam int PtrBits = $clog2(Depth);
    localparam int CntBits = $clog2(Depth + 1);

    logic [Width-1:0]   mem_r [Depth];
    logic [PtrBits-1:0] wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [CntBits-1:0] cnt_r, left_s, cnt_nxt_s;
    logic               valid_r;
    logic [Width-1:0]   head_r, head_nxt_s;

    function automatic logic [PtrBits-1:0] ptr_inc(input logic [PtrBits-1:0] p);
        return (p == PtrBits'(Depth - 1)) ? {PtrBits{1'b0}} : p + 1'b1;
    endfunction

    // Look ahead to the entry that will sit at the head after this cycle
    always_comb begin
        rd_nxt_s  = pop ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        left_s    = cnt_r - {{(CntBits-1){1'b0}}, pop};
        cnt_nxt_s = left_s + {{(CntBits-1){1'b0}}, push};
        if (cnt_nxt_s == {CntBits{1'b0}}) begin
            head_nxt_s = head_r;
        end else if (left_s == {CntBits{1'b0}}) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Pointer, occupancy and registered head state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            valid_r  <= 1'b0;
            head_r   <= '0;
        end else begin
            if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
            rd_ptr_r <= rd_nxt_s;
            cnt_r    <= cnt_nxt_s;
            valid_r  <= (cnt_nxt_s != {CntBits{1'b0}});
            head_r   <= head_nxt_s;
        end
    end

    // Storage array; contents need no reset since occupancy is cleared
    always_ff @(posedge clk) begin
        if (push && !rst) mem_r[wr_ptr_r] <= push_data;
    end

    assign out_valid = valid_r;
    assign out_data  = head_r;
endmodule

// File: rtl/sum_bits.sv
// Pipelined popcount: nibble counts are registered first, then the nibble
// total travels through Latency-1 further stages.
module sum_bits
    import popcount_pkg::*;
#(
    parameter int InBits  = 32,
    parameter int OutBits = 6,
    parameter int Latency = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [InBits-1:0]  in_bits,
    output logic [OutBits-1:0] sum
);
    localparam int Nibs = InBits / 4;

    logic [2:0]         nib_cnt_r [Nibs];
    logic [OutBits-1:0] tot_s;
    logic [OutBits-1:0] dly_r [Latency-1];

    // First stage: per-nibble ones counts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Nibs; k++) nib_cnt_r[k] <= 3'd0;
        end else if (en) begin
            for (int k = 0; k < Nibs; k++) nib_cnt_r[k] <= nibble_ones(in_bits[4*k +: 4]);
        end
    end

    // Adder over the registered nibble counts
    always_comb begin
        tot_s = '0;
        for (int k = 0; k < Nibs; k++) begin
            tot_s = tot_s + {{(OutBits-3){1'b0}}, nib_cnt_r[k]};
        end
    end

    // Remaining stages carry the total to the output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < Latency-1; j++) dly_r[j] <= '0;
        end else if (en) begin
            dly_r[0] <= tot_s;
            for (int j = 1; j < Latency-1; j++) dly_r[j] <= dly_r[j-1];
        end
    end

    assign sum = dly_r[Latency-2];
endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin sharing of one pipelined sum_bits unit among NumReq requesters.
// Define POPCOUNT_ARB_STATS_EN to add per-requester saturating grant counters.
module popcount_arbiter
    import popcount_pkg::*;
#(
    parameter int NumReq = NUM_REQ,
    parameter int InBits = IN_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    popcount_arbiter_if.slave     bus
`ifdef POPCOUNT_ARB_STATS_EN
    ,
    output logic [NumReq*16-1:0]  grant_cnt
`endif
);
    localparam int IdBits    = id_bits(NumReq);
    localparam int OutBits   = out_bits(InBits);
    localparam int Latency   = pipe_latency(InBits);
    localparam int FifoDepth = Latency + 2;
    localparam int CredBits  = $clog2(FifoDepth + 1);

    logic [IdBits-1:0]   rr_ptr_r;
    logic [CredBits-1:0] credits_r;
    logic [IdBits-1:0]   win_id_s;
    logic                win_found_s;
    logic                issue_s;
    logic [NumReq-1:0]   grant_s;
    logic [InBits-1:0]   sel_bits_s;
    logic [OutBits-1:0]  sum_s;
    logic [Latency-1:0]  tag_vld_r;
    logic [IdBits-1:0]   tag_id_r [Latency];
    logic                push_s, pop_s, fifo_valid_s;
    logic [IdBits+OutBits-1:0] fifo_data_s;

    // Round-robin search from rr_ptr; lower offsets overwrite later ones
    always_comb begin
        int idx;
        idx         = 0;
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx         = (int'(rr_ptr_r) + i) % NumReq;
            win_id_s    = bus.req_valid[idx] ? IdBits'(idx) : win_id_s;
            win_found_s = win_found_s | bus.req_valid[idx];
        end
        issue_s    = win_found_s && (credits_r != {CredBits{1'b0}}) && !rst;
        grant_s    = issue_s ? ({{(NumReq-1){1'b0}}, 1'b1} << win_id_s) : {NumReq{1'b0}};
        sel_bits_s = bus.req_bits[win_id_s*InBits +: InBits];
    end

    // Pointer moves past the winner only when something was issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (issue_s) begin
            rr_ptr_r <= (win_id_s == IdBits'(NumReq - 1)) ? {IdBits{1'b0}} : win_id_s + 1'b1;
        end
    end

    // A credit covers a FIFO slot from issue until its result is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r <= CredBits'(FifoDepth);
        end else begin
            case ({issue_s, pop_s})
                2'b10:   credits_r <= credits_r - 1'b1;
                2'b01:   credits_r <= credits_r + 1'b1;
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Tag pipe matched to the sum_bits latency
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r <= '0;
            for (int j = 0; j < Latency; j++) tag_id_r[j] <= '0;
        end else begin
            tag_vld_r   <= {tag_vld_r[Latency-2:0], issue_s};
            tag_id_r[0] <= win_id_s;
            for (int j = 1; j < Latency; j++) tag_id_r[j] <= tag_id_r[j-1];
        end
    end

    sum_bits #(
        .InBits  (InBits),
        .OutBits (OutBits),
        .Latency (Latency)
    ) u_sum_bits (
        .clk     (clk),
        .rst     (rst),
        .en      (1'b1),
        .in_bits (sel_bits_s),
        .sum     (sum_s)
    );

    assign push_s = tag_vld_r[Latency-1];
    assign pop_s  = fifo_valid_s & bus.rsp_ready;

    popcount_rsp_fifo #(
        .Width (IdBits + OutBits),
        .Depth (FifoDepth)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({tag_id_r[Latency-1], sum_s}),
        .pop       (pop_s),
        .out_valid (fifo_valid_s),
        .out_data  (fifo_data_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = fifo_valid_s;
    assign bus.rsp_id    = fifo_data_s[IdBits+OutBits-1:OutBits];
    assign bus.rsp_sum   = fifo_data_s[OutBits-1:0];

`ifdef POPCOUNT_ARB_STATS_EN
    logic [NumReq*16-1:0] grant_cnt_r;

    // Saturating grant counters, one per requester
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_r <= '0;
        end else begin
            for (int r = 0; r < NumReq; r++) begin
                if (grant_s[r] && (grant_cnt_r[r*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt_r[r*16 +: 16] <= grant_cnt_r[r*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_r;
`endif
endmodule
